// File: rtl/pulse_width_meter_pkg.sv
// Shared types and constants for the pulse width meter.
package pulse_width_meter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  localparam int unsigned CNT_W_DEF = 8;

  // Largest value representable in a w-bit unsigned counter.
  function automatic logic [31:0] sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/pulse_width_meter_edge_det.sv
// Edge detector on enabled samples; d_prev resets high so a line that is
// already high at reset release does not look like a rising edge.
module edge_det (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic rise_o,
  output logic fall_o
);

  logic d_prev;

  assign rise = en & d & ~d_prev;
  assign fall = en & ~d & d_prev;

  // Track the last enabled sample and register the edge strobes.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      d_prev <= 1'b1;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      if (en) d_prev <= d;
      rise_o <= rise;
      fall_o <= fall;
    end
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high-pulse widths of d in enabled samples and presents each
// completed width through a one-entry valid/ready result register.
//
// state   | meaning
// IDLE    | waiting for a rising edge on an enabled sample
// HIGH    | inside a pulse, counting enabled samples with d=1
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             d,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] width_o,
  output logic             ovf_o,
  output logic             drop_o,
  output logic             rise_o,
  output logic             fall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rise;
  logic             fall;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic             complete;
  logic             accept;

  edge_det u_edge_det (
    .clk    (clk),
    .res    (res),
    .en     (en),
    .d      (d),
    .rise   (rise),
    .fall   (fall),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  // Measurement state register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next-state logic: start on rise, count enabled highs, finish on fall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = CNT_ONE;
          ovf_nxt   = 1'b0;
        end
      end
      ST_HIGH: begin
        if (en & d) begin
          if (cnt == CNT_MAX) ovf_nxt = 1'b1;
          else                cnt_nxt = cnt + CNT_ONE;
        end else if (fall) begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The register can take a new result when empty or being drained now.
  assign accept = ~valid_o | ready_i;

  // Result register with handshake and sticky drop flag.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      valid_o <= 1'b0;
      width_o <= '0;
      ovf_o   <= 1'b0;
      drop_o  <= 1'b0;
    end else begin
      if (complete) begin
        if (accept) begin
          valid_o <= 1'b1;
          width_o <= cnt;
          ovf_o   <= ovf;
        end else begin
          drop_o  <= 1'b1;
        end
      end else if (valid_o & ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench: directed table, hand sequences and random stimulus
// against a pulse-level reference model.
module tb_pulse_width_meter;

  localparam int MAX8 = 255;

  logic       clk = 1'b0;
  logic       res;
  logic       en, d, d4, rdy;
  logic       valid, ovf, drop, rise, fall;
  logic [7:0] width;
  logic       valid4, ovf4, drop4, rise4, fall4;
  logic [3:0] width4;

  int errors = 0;
  int checks = 0;

  // Reference model state (pulse-level view for the 8-bit instance).
  bit m_prev, m_in, m_valid, m_ovf, m_drop, m_rise, m_fall;
  int m_n, m_w;

  typedef struct {
    logic       en, d, rdy;
    logic       rise, fall, valid;
    logic [7:0] width;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  pulse_width_meter #(.CNT_W(8)) dut (
    .clk(clk), .res(res), .en(en), .d(d), .ready_i(rdy),
    .valid_o(valid), .width_o(width), .ovf_o(ovf), .drop_o(drop),
    .rise_o(rise), .fall_o(fall)
  );

  pulse_width_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .res(res), .en(en), .d(d4), .ready_i(rdy),
    .valid_o(valid4), .width_o(width4), .ovf_o(ovf4), .drop_o(drop4),
    .rise_o(rise4), .fall_o(fall4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 1; m_in = 0; m_n = 0; m_valid = 0; m_w = 0;
    m_ovf = 0; m_drop = 0; m_rise = 0; m_fall = 0;
  endtask

  task automatic model_step();
    bit r, f, c;
    if (res) begin
      model_reset();
      return;
    end
    r = en && d && !m_prev;
    f = en && !d && m_prev;
    c = m_in && f;
    if (c) begin
      if (!m_valid || rdy) begin
        m_valid = 1;
        m_w     = (m_n > MAX8) ? MAX8 : m_n;
        m_ovf   = (m_n > MAX8);
      end else begin
        m_drop = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (c)                    m_in = 0;
    else if (!m_in && r)      begin m_in = 1; m_n = 1; end
    else if (m_in && en && d) m_n++;
    if (en) m_prev = d;
    m_rise = r;
    m_fall = f;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", {19'd0, valid, width, ovf, drop, rise, fall},
          {19'd0, m_valid, m_w[7:0], m_ovf, m_drop, m_rise, m_fall});
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int n);
    d = 1; ticks(n);
    d = 0; tick();
  endtask

  initial begin
    res = 1; en = 0; d = 0; d4 = 0; rdy = 0;
    model_reset();

    // 1: reset with toggling inputs, all outputs low
    for (int i = 0; i < 3; i++) begin
      en = i[0]; d = ~i[0]; rdy = i[0]; d4 = i[0];
      @(posedge clk); #1;
      check("reset_outs", {valid, width, ovf, drop, rise, fall},
            14'd0);
      check("reset_outs4", {valid4, width4, ovf4, drop4, rise4, fall4}, 10'd0);
      @(negedge clk);
    end
    res = 0; en = 1; d = 0; d4 = 0; rdy = 1;
    model_reset();
    tick();
    check("post_reset_rise", rise, 1'b0);
    check("post_reset_valid", valid, 1'b0);
    ticks(2);

    // 2: table-driven 5-sample pulse
    vecs[0] = '{1, 1, 1, 1, 0, 0, 8'd0};
    vecs[1] = '{1, 1, 1, 0, 0, 0, 8'd0};
    vecs[2] = '{1, 1, 1, 0, 0, 0, 8'd0};
    vecs[3] = '{1, 1, 1, 0, 0, 0, 8'd0};
    vecs[4] = '{1, 1, 1, 0, 0, 0, 8'd0};
    vecs[5] = '{1, 0, 1, 0, 1, 1, 8'd5};
    vecs[6] = '{1, 0, 1, 0, 0, 0, 8'd5};
    for (int i = 0; i < 7; i++) begin
      en = vecs[i].en; d = vecs[i].d; rdy = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d", i), {rise, fall, valid, width},
            {vecs[i].rise, vecs[i].fall, vecs[i].valid, vecs[i].width});
    end
    check("vec_ovf", ovf, 1'b0);

    // 3: enable every other cycle over 6 high clocks
    d = 1;
    for (int i = 0; i < 6; i++) begin
      en = (i % 2 == 0);
      tick();
    end
    en = 0; d = 0; tick();
    en = 1; tick();
    check("gated_valid", valid, 1'b1);
    check("gated_width", width, 8'd3);
    tick();

    // 4: 4-bit instance saturation, then a normal pulse
    d4 = 1; ticks(20);
    d4 = 0; tick();
    check("sat4_valid", valid4, 1'b1);
    check("sat4_width", width4, 4'd15);
    check("sat4_ovf", ovf4, 1'b1);
    tick();
    d4 = 1; ticks(2);
    d4 = 0; tick();
    check("p2_4_width", width4, 4'd2);
    check("p2_4_ovf", ovf4, 1'b0);
    check("p2_4_valid", valid4, 1'b1);
    tick();

    // 8-bit saturation boundary: 300 samples saturate, 255 exactly does not
    pulse(300);
    check("sat8_width", width, 8'd255);
    check("sat8_ovf", ovf, 1'b1);
    tick();
    pulse(255);
    check("max8_width", width, 8'd255);
    check("max8_ovf", ovf, 1'b0);
    tick();

    // 5: back-pressure and drop
    rdy = 0;
    pulse(3);
    pulse(4);
    check("bp_width", width, 8'd3);
    check("bp_drop", drop, 1'b1);
    check("bp_valid", valid, 1'b1);
    rdy = 1; tick();
    check("bp_consumed", valid, 1'b0);
    pulse(2);
    check("bp_next_width", width, 8'd2);
    check("bp_drop_sticky", drop, 1'b1);
    tick();

    // 6: high at reset release, then reset in the middle of a pulse
    res = 1; d = 1; model_reset();
    @(negedge clk);
    res = 0; tick();
    check("hi_release_rise", rise, 1'b0);
    d = 0; tick(); tick();
    check("hi_release_valid", valid, 1'b0);
    d = 1; ticks(3);
    res = 1; #1;
    check("async_reset", {valid, width, ovf, drop, rise, fall}, 14'd0);
    model_reset();
    @(negedge clk);
    tick();
    res = 0; ticks(3);
    d = 0; ticks(2);
    check("mid_reset_valid", valid, 1'b0);
    check("mid_reset_drop", drop, 1'b0);

    // Random stimulus against the model
    for (int i = 0; i < 2000; i++) begin
      en  = ($urandom_range(0, 9) < 7);
      rdy = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) d = ~d;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
